// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with req/ack byte delivery and framing/overrun error pulses.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity check and rxperr pulse.
module uart_rx #(
    parameter int SYSHZ = 100_000_000,
    parameter int BAUD  = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rxreq,
    input  logic       rxack,
    output logic [7:0] rxdata,
    output logic       rxferr,
    output logic       rxovr,
    output logic       rxperr
);
    localparam int INT = SYSHZ / BAUD;
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAITHI} state_t;
    logic nperr;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;
`endif
    state_t state, nstate;
    logic s1, rx_s, sample;
    logic [31:0] timer, ntimer;
    logic [2:0] bitcnt, nbitcnt;
    logic [7:0] shreg, nshreg, nrxdata;
    logic nrxreq, nferr, novr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b1;
            rx_s   <= 1'b1;
            state  <= IDLE;
            timer  <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            rxreq  <= 1'b0;
            rxdata <= '0;
            rxferr <= 1'b0;
            rxovr  <= 1'b0;
        end else begin
            s1     <= rx;
            rx_s   <= s1;
            state  <= nstate;
            timer  <= ntimer;
            bitcnt <= nbitcnt;
            shreg  <= nshreg;
            rxreq  <= nrxreq;
            rxdata <= nrxdata;
            rxferr <= nferr;
            rxovr  <= novr;
        end
    end
`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rxperr <= 1'b0;
        else     rxperr <= nperr;
    end
`else
    assign rxperr = 1'b0;
`endif
    // A pending ack always clears rxreq, so a byte finishing on the same edge counts as overrun.
    always_comb begin
        sample  = timer == 32'd0;
        nstate  = state;
        ntimer  = sample ? 32'(INT - 1) : timer - 32'd1;
        nbitcnt = bitcnt;
        nshreg  = shreg;
        nrxreq  = rxreq & ~rxack;
        nrxdata = rxdata;
        nferr   = 1'b0;
        novr    = 1'b0;
`ifdef UART_RX_PARITY_EN
        nperr   = 1'b0;
`endif
        case (state)
            IDLE: if (!rx_s) begin
                nstate = START;
                ntimer = 32'(INT / 2 - 1);
            end
            START: if (sample) begin
                nstate  = rx_s ? IDLE : DATA;
                nbitcnt = 3'd0;
            end
            DATA: if (sample) begin
                nshreg  = {rx_s, shreg[7:1]};
                nbitcnt = bitcnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (bitcnt == 3'd7) nstate = PARITY;
`else
                if (bitcnt == 3'd7) nstate = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (sample) begin
                nperr  = ^{shreg, rx_s};
                nstate = nperr ? IDLE : STOP;
            end
`endif
            STOP: if (sample) begin
                nstate = rx_s ? IDLE : WAITHI;
                nferr  = !rx_s;
                novr   = rx_s && rxreq;
                if (rx_s && !rxreq) begin
                    nrxdata = shreg;
                    nrxreq  = 1'b1;
                end
            end
            WAITHI: if (rx_s) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a frame-level model of the receiver.
module tb_uart_rx;
    localparam int INT = 10;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = INT / 2 + 10 * INT + 3;
`else
    localparam int LAT = INT / 2 + 9 * INT + 3;
`endif
    logic clk = 0, rst = 1, rx = 1, rxack = 0;
    logic rxreq, rxferr, rxovr, rxperr;
    logic [7:0] rxdata;
    always #5 clk = ~clk;
    uart_rx #(.SYSHZ(1_000_000), .BAUD(100_000)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rxreq(rxreq), .rxack(rxack),
        .rxdata(rxdata), .rxferr(rxferr), .rxovr(rxovr), .rxperr(rxperr)
    );
    int ncmp = 0, nfail = 0;
    int cyc = 0, start_cyc = 0, rise_cyc = 0;
    int nferr = 0, novr = 0, nperr = 0, nrise = 0;
    int eferr = 0, eovr = 0, eperr = 0, erise = 0;
    logic req_q = 0, pend = 0;
    logic [7:0] mdata = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        nferr += int'(rxferr);
        novr  += int'(rxovr);
        nperr += int'(rxperr);
        if (rxreq && !req_q) begin
            nrise++;
            rise_cyc = cyc;
        end
        req_q = rxreq;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic [7:0] b, input logic stop, input logic badp);
        start_cyc = cyc;
        rx = 0;
        repeat (INT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (INT) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = ^b ^ badp;
        repeat (INT) @(negedge clk);
`endif
        rx = stop;
        repeat (INT) @(negedge clk);
        rx = 1;
        repeat (2 * INT) @(negedge clk);
    endtask
    task automatic send(input logic [7:0] b, input logic stop, input logic badp);
        logic perr_f = 0;
        drive(b, stop, badp);
`ifdef UART_RX_PARITY_EN
        perr_f = badp;
`endif
        if (perr_f) eperr++;
        else if (!stop) eferr++;
        else if (pend) eovr++;
        else begin
            pend = 1;
            mdata = b;
            erise++;
        end
    endtask
    task automatic ack();
        rxack = 1;
        @(negedge clk);
        rxack = 0;
        pend = 0;
    endtask
    task automatic check_all(input string tag);
        chk({tag, ".req"}, 32'(rxreq), 32'(pend));
        chk({tag, ".data"}, 32'(rxdata), 32'(mdata));
        chk({tag, ".ferr"}, nferr, eferr);
        chk({tag, ".ovr"}, novr, eovr);
        chk({tag, ".perr"}, nperr, eperr);
        chk({tag, ".rise"}, nrise, erise);
    endtask
    initial begin
        #1;
        chk("rst.req", 32'(rxreq), 0);
        chk("rst.data", 32'(rxdata), 0);
        chk("rst.err", 32'({rxferr, rxovr, rxperr}), 0);
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (INT) @(negedge clk);
        send(8'hA5, 1, 0);
        check_all("a5");
        chk("a5.lat", 32'(rise_cyc - start_cyc), 32'(LAT));
        ack();
        check_all("a5ack");
        send(8'hA5, 1, 0);
        send(8'h3C, 1, 0);
        check_all("ovr");
        ack();
        send(8'h55, 0, 0);
        check_all("ferr");
        send(8'h01, 1, 0);
        check_all("after_ferr");
        ack();
        rx = 0;
        repeat (3) @(negedge clk);
        rx = 1;
        repeat (3 * INT) @(negedge clk);
        check_all("glitch");
        send(8'h5A, 1, 0);
        fork
            drive(8'hFF, 1, 0);
            begin
                repeat (INT + 4 * INT + INT / 2) @(negedge clk);
                rst = 1;
                #1;
                chk("midrst.req", 32'(rxreq), 0);
                chk("midrst.data", 32'(rxdata), 0);
                chk("midrst.err", 32'({rxferr, rxovr, rxperr}), 0);
                @(negedge clk);
                rst = 0;
                pend = 0;
                mdata = 0;
            end
        join
        check_all("midrst");
        send(8'h12, 1, 0);
        check_all("after_rst");
        ack();
`ifdef UART_RX_PARITY_EN
        send(8'h07, 1, 0);
        check_all("par_ok");
        ack();
        send(8'h07, 1, 1);
        check_all("par_bad");
`endif
        for (int k = 0; k < 24; k++) begin
            send(8'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0);
            check_all($sformatf("rnd%0d", k));
            if ($urandom_range(0, 1) != 0) begin
                ack();
                check_all($sformatf("rndack%0d", k));
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
